// File: rtl/moore_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : moore_seq_pkg
//  Purpose  : State encodings and shared types for the "1101" Moore detector.
//  Revision : 1.0  initial release
// ============================================================================
package moore_seq_pkg;

    typedef enum logic [2:0] {
        ST_A = 3'b000,
        ST_B = 3'b010,
        ST_C = 3'b110,
        ST_D = 3'b100,
        ST_E = 3'b011
    } state_t;

    localparam state_t DET_STATE = ST_E;

endpackage : moore_seq_pkg
`default_nettype wire

// File: rtl/moore_seq_step.sv
`default_nettype none
// ============================================================================
//  Module   : moore_seq_step
//  Purpose  : Combinational next-state engine for the "1101" Moore detector.
//  Revision : 1.0  initial release
// ============================================================================
module moore_seq_step
    import moore_seq_pkg::*;
(
    input  state_t i_state,
    input  logic   i_bit,
    output state_t o_next,
    output logic   o_hit
);

    always_comb begin
        o_next = ST_A;
        case (i_state)
            ST_A:    o_next = i_bit ? ST_B : ST_A;
            ST_B:    o_next = i_bit ? ST_C : ST_A;
            ST_C:    o_next = i_bit ? ST_C : ST_D;
            ST_D:    o_next = i_bit ? ST_E : ST_A;
            ST_E:    o_next = i_bit ? ST_C : ST_A;
            default: o_next = ST_A;
        endcase
        o_hit = (o_next == DET_STATE);
    end

endmodule : moore_seq_step
`default_nettype wire

// File: rtl/moore_seq_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : moore_seq_scheduler
//  Purpose  : Round-robin time-sharing of one "1101" detector engine over NCH
//             serial channels, each with its own saved state and hit counter.
//  Revision : 1.0  initial release
// ============================================================================
module moore_seq_scheduler
    import moore_seq_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CW   = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  in_valid,
    input  logic [NCH-1:0]  in_bit,
    input  logic [NCH-1:0]  enable,
    input  logic [NCH-1:0]  clear,
    output logic [NCH-1:0]  in_ready,
    output logic [NCH-1:0]  det,
    input  logic [SELW-1:0] state_sel,
    output logic [2:0]      state_out,
    output logic [CW-1:0]   count_out
);

    localparam logic [CW-1:0] C_CNT_MAX = '1;

    state_t          r_state_q [NCH];
    state_t          w_state_d [NCH];
    logic [CW-1:0]   r_count_q [NCH];
    logic [CW-1:0]   w_count_d [NCH];
    logic [NCH-1:0]  r_det_q,  w_det_d;
    logic [SELW-1:0] r_rr_q,   w_rr_d;

    logic [NCH-1:0]  w_elig;
    logic [NCH-1:0]  w_grant;
    logic [SELW-1:0] w_gidx;
    logic            w_gvld;
    state_t          w_cur_state;
    logic            w_cur_bit;
    state_t          w_next;
    logic            w_hit;

    // Pick the eligible channel with the smallest cyclic distance from rr_ptr.
    always_comb begin
        int v_best;
        int v_dist;
        v_best = NCH;
        v_dist = 0;
        w_gidx = '0;
        w_elig = in_valid & enable & ~clear;
        for (int i = 0; i < NCH; i++) begin
            if (w_elig[i]) begin
                v_dist = (i >= int'(r_rr_q)) ? (i - int'(r_rr_q))
                                             : (i + NCH - int'(r_rr_q));
                if (v_dist < v_best) begin
                    v_best = v_dist;
                    w_gidx = SELW'(i);
                end
            end
        end
        w_gvld = (v_best < NCH);
        for (int i = 0; i < NCH; i++) begin
            w_grant[i] = w_gvld && (w_gidx == SELW'(i));
        end
    end

    always_comb begin
        w_cur_state = ST_A;
        w_cur_bit   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gidx == SELW'(i)) begin
                w_cur_state = r_state_q[i];
                w_cur_bit   = in_bit[i];
            end
        end
    end

    moore_seq_step u_step (
        .i_state (w_cur_state),
        .i_bit   (w_cur_bit),
        .o_next  (w_next),
        .o_hit   (w_hit)
    );

    always_comb begin
        w_rr_d = r_rr_q;
        if (w_gvld) begin
            w_rr_d = (w_gidx == SELW'(NCH - 1)) ? '0 : w_gidx + 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            w_state_d[i] = r_state_q[i];
            w_count_d[i] = r_count_q[i];
            w_det_d[i]   = 1'b0;
            if (w_grant[i]) begin
                w_state_d[i] = w_next;
                w_det_d[i]   = w_hit;
                if (w_hit && (r_count_q[i] != C_CNT_MAX)) begin
                    w_count_d[i] = r_count_q[i] + 1'b1;
                end
            end
            // A clearing channel is never granted, so this cannot drop a hit.
            if (clear[i]) begin
                w_state_d[i] = ST_A;
                w_count_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_state_q[i] <= ST_A;
                r_count_q[i] <= '0;
            end
            r_det_q <= '0;
            r_rr_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state_q[i] <= w_state_d[i];
                r_count_q[i] <= w_count_d[i];
            end
            r_det_q <= w_det_d;
            r_rr_q  <= w_rr_d;
        end
    end

    assign in_ready = rst_n ? '0 : w_grant;
    assign det      = r_det_q;

    always_comb begin
        state_out = 3'b000;
        count_out = '0;
        for (int i = 0; i < NCH; i++) begin
            if (state_sel == SELW'(i)) begin
                state_out = r_state_q[i];
                count_out = r_count_q[i];
            end
        end
    end

endmodule : moore_seq_scheduler
`default_nettype wire

// File: doc/moore_seq_scheduler.md
Name: moore_seq_scheduler

Overview:
- Time-shares one "1101" Moore sequence-detector next-state engine among NCH serial bit channels.
- Each channel keeps its own 3-bit state register and hit counter.
- A round-robin arbiter grants one requesting channel per cycle. That channel's bit advances its saved state through the shared engine, and a per-channel detect pulse is raised.
- Sits between the pin-level input sampling and the tt_um top wrapper. The wrapper maps channels onto ui_in/uo_out.

Parameters:
- NCH, 4: number of serial channels (2..8).
- CW, 8: hit-counter width per channel.
- SELW, $clog2(NCH): width of the readback select.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-high: 1 on a rising clk edge resets the block.
- in_valid  in  NCH  channel i has a bit pending.
- in_bit  in  NCH  serial bit of channel i, qualified by in_valid[i].
- enable  in  NCH  channel i is allowed to be scheduled.
- clear  in  NCH  pulse: reset channel i's state and counter.
- in_ready  out  NCH  one-hot grant; channel i's bit is consumed this cycle.
- det  out  NCH  registered one-cycle pulse: channel i just entered state E.
- state_sel  in  SELW  channel chosen for readback.
- state_out  out  3  saved state of channel state_sel (combinational mux).
- count_out  out  CW  hit count of channel state_sel (combinational mux).

Behaviour:
- State encoding: A=000, B=010, C=110, D=100, E=011. Moore output is state[0] (1 only in E).
- Next-state table (bit 0 / bit 1):
  - A: A / B
  - B: A / C
  - C: D / C
  - D: A / E
  - E: A / C
  - any illegal code: A (on either bit).
- Eligible set: in_valid & enable & ~clear.
- Arbitration:
  - in_ready is combinational: one-hot on the first eligible channel at or after rr_ptr (cyclic order); all-zero if none eligible.
  - On a grant to channel g at a clock edge, rr_ptr <= (g+1) mod NCH. With no grant, rr_ptr holds.
- Update at the edge of a granted cycle:
  - state[g] <= next(state[g], in_bit[g]).
  - det[g] <= (next == E). All other det bits <= 0, so det is at most one-hot and each pulse lasts one cycle.
  - If next == E, count[g] increments, saturating at 2^CW-1.
- Latency: bit granted in cycle t → det visible in cycle t+1. The new state is visible on state_out in t+1.
- Ungranted channels hold state and counter. A producer holds in_valid/in_bit until in_ready is seen.
- clear[i]:
  - Sets state[i] <= A and count[i] <= 0.
  - clear beats grant: a clearing channel is not eligible that cycle, and its bit stays pending.
- Clearing enable[i] freezes channel i's state; re-enabling resumes from the saved state.
- rst_n = 1:
  - all states = A, all counts = 0, rr_ptr = 0, det = 0.
  - in_ready is forced to 0 while reset is asserted.
  - Reset mid-stream discards all partial matches.
- Overlap: after E, a 1 goes to C, so "1101101" yields two detections.
- state_sel ≥ NCH returns state_out = 0 and count_out = 0.

Decomposition:
- Shared package moore_seq_pkg:
  - state encodings ST_A..ST_E and the 3-bit state typedef.
  - DET_STATE constant (= ST_E).
- Sub-module moore_seq_step: purely combinational (state, bit) → (next, hit). This is the single shared engine, instantiated once.
- Arbiter and per-channel storage stay in the top module.

Test Plan:
- Reset, then channel 0 only, bits 1,1,0,1 (one per cycle) → in_ready[0] each cycle; states B,C,D,E; det[0]=1 exactly in the cycle after the 4th bit; count 0 = 1.
- All 4 channels hold in_valid=1 continuously → grants rotate 0,1,2,3,0,... one per cycle. Each channel advances once per 4 cycles.
- Channel 2 streams 1,1,0,1,1,0,1 interleaved with channel 1 traffic → det[2] fires twice (overlap); count 2 = 2; channel 1 state is unaffected.
- CW=2, channel 3 streams "1101" four times → count 3 saturates at 3, and det[3] still pulses on every match.
- Channel 0 is in D with clear[0] and in_valid[0]=1 in the same cycle → no grant to 0; state 0 becomes A, count 0 becomes 0; the bit is taken next cycle from A.
- Channel 1 mid-pattern (state C), assert rst_n for 1 cycle → all states A, counts 0, rr_ptr 0. The next grant goes to the lowest eligible channel.
